// File: rtl/pcie_cfg_mgmt_arb_if.sv
// Requester and endpoint cfg_mgmt signal bundle for pcie_cfg_mgmt_arb.
// Per-requester fields are packed [N_REQ-1:0][W-1:0], so slice i sits at [W*i +: W].
interface pcie_cfg_mgmt_arb_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       req_write;
  logic [N_REQ-1:0][18:0] req_addr;
  logic [N_REQ-1:0][31:0] req_wdata;
  logic [N_REQ-1:0][3:0]  req_be;
  logic [N_REQ-1:0]       resp_valid;
  logic [31:0]            resp_rdata;
  logic                   resp_timeout;
  logic [18:0]            cfg_mgmt_addr;
  logic                   cfg_mgmt_write;
  logic                   cfg_mgmt_read;
  logic [31:0]            cfg_mgmt_write_data;
  logic [3:0]             cfg_mgmt_byte_enable;
  logic [31:0]            cfg_mgmt_read_data;
  logic                   cfg_mgmt_read_write_done;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
           cfg_mgmt_read_data, cfg_mgmt_read_write_done,
    output req_ready, resp_valid, resp_rdata, resp_timeout,
           cfg_mgmt_addr, cfg_mgmt_write, cfg_mgmt_read,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
           cfg_mgmt_read_data, cfg_mgmt_read_write_done,
    input  req_ready, resp_valid, resp_rdata, resp_timeout,
           cfg_mgmt_addr, cfg_mgmt_write, cfg_mgmt_read,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable
  );
endinterface

// File: rtl/pcie_cfg_mgmt_arb.sv
// Round-robin arbiter sharing the PCIe cfg_mgmt port between N_REQ requesters.
// One access in flight; strobes held until done or the timeout aborts the access.
module pcie_cfg_mgmt_arb #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_user,
  input  logic                 rst_user_n,
  pcie_cfg_mgmt_arb_if.slave   bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, gnt_idx, pick_idx, idx;
  logic            pick_vld;
  logic [TW-1:0]   timer;
  logic            fin, fin_to;
  logic [18:0]     addr_q;
  logic [31:0]     wdata_q, rdata_q;
  logic [3:0]      be_q;
  logic            wr_q, rd_q, to_q;

  // Scan from rr_ptr downward in priority: the last hit in a descending loop is the nearest one.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr;
    idx      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % N_REQ);
      if (bus.req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    fin_to    = 1'b0;
    case (state)
      IDLE:   if (pick_vld) state_nxt = ACCESS;
      ACCESS: begin
        // done beats the timeout when both land in the same cycle
        if (bus.cfg_mgmt_read_write_done) begin
          fin       = 1'b1;
          state_nxt = RESP;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          fin       = 1'b1;
          fin_to    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_user or negedge rst_user_n) begin
    if (!rst_user_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_idx <= '0;
      timer   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (pick_vld) begin
          gnt_idx <= pick_idx;
          rr_ptr  <= (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
          addr_q  <= bus.req_addr[pick_idx];
          wdata_q <= bus.req_wdata[pick_idx];
          be_q    <= bus.req_be[pick_idx];
          wr_q    <= bus.req_write[pick_idx];
          rd_q    <= ~bus.req_write[pick_idx];
        end
        ACCESS: begin
          timer <= timer + TW'(1);
          if (fin) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            rdata_q <= fin_to ? 32'hFFFF_FFFF : (wr_q ? 32'h0 : bus.cfg_mgmt_read_data);
            to_q    <= fin_to;
          end
        end
        RESP:    timer <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready            = (state == IDLE && pick_vld) ? (N_REQ'(1) << pick_idx) : '0;
    bus.resp_valid           = (state == RESP) ? (N_REQ'(1) << gnt_idx) : '0;
    bus.resp_rdata           = rdata_q;
    bus.resp_timeout         = to_q;
    bus.cfg_mgmt_addr        = addr_q;
    bus.cfg_mgmt_write       = wr_q;
    bus.cfg_mgmt_read        = rd_q;
    bus.cfg_mgmt_write_data  = wdata_q;
    bus.cfg_mgmt_byte_enable = be_q;
  end
endmodule

// File: tb/tb_pcie_cfg_mgmt_arb.sv
// Bench for pcie_cfg_mgmt_arb: transaction-schedule model, vector table, random traffic, reset corners.
module tb_pcie_cfg_mgmt_arb;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pcie_cfg_mgmt_arb_if #(.N_REQ(N)) bus ();
  pcie_cfg_mgmt_arb #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_user(clk), .rst_user_n(rst_n), .bus(bus)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;

  // pending requests per requester
  bit          pend[N];
  logic        pw[N];
  logic [18:0] pa[N];
  logic [31:0] pd[N];
  logic [3:0]  pb[N];

  // model: schedule of the one transaction in flight (grant cycle, access length)
  int          m_ptr = 0;
  bit          m_act = 0;
  int          m_g, m_t, m_k;
  bit          m_to, m_w;
  logic [18:0] m_a;
  logic [31:0] m_d, m_cd;
  logic [3:0]  m_b;
  logic [31:0] m_last_rd = '0;
  bit          m_last_to = 0;
  logic [31:0] seen_rd;
  logic        seen_to;

  typedef struct {
    int          req;
    bit          wr;
    logic [18:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    int          d;
    logic [31:0] cd;
    bit          stale;
    logic [31:0] erd;
    bit          eto;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic new_req(int i, bit force_wr);
    pend[i] = 1'b1;
    pw[i]   = force_wr ? 1'b1 : 1'($urandom_range(1));
    pa[i]   = 19'($urandom);
    pd[i]   = $urandom;
    pb[i]   = 4'($urandom);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_write[i] = pw[i];
      bus.req_addr[i]  = pa[i];
      bus.req_wdata[i] = pd[i];
      bus.req_be[i]    = pb[i];
    end
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_ready"}, 32'(bus.req_ready), 32'h0);
    chk({nm, "_rvalid"}, 32'(bus.resp_valid), 32'h0);
    chk({nm, "_rdata"}, bus.resp_rdata, 32'h0);
    chk({nm, "_rto"}, 32'(bus.resp_timeout), 32'h0);
    chk({nm, "_addr"}, 32'(bus.cfg_mgmt_addr), 32'h0);
    chk({nm, "_strb"}, 32'({bus.cfg_mgmt_write, bus.cfg_mgmt_read}), 32'h0);
    chk({nm, "_wdata"}, bus.cfg_mgmt_write_data, 32'h0);
    chk({nm, "_be"}, 32'(bus.cfg_mgmt_byte_enable), 32'h0);
  endtask

  // Cycle loop: generate requests, predict grant/strobe/resp windows from the schedule, compare.
  task automatic run(int ncyc, int p_new, bit all_wr, int fix_d, bit fix_cd_en,
                     logic [31:0] fix_cd, bit stale, bit stale_first);
    bit gen, drained, g_now, in_acc, in_resp, any;
    logic [N-1:0] exp_rdy;
    int d;
    drained = 1'b0;
    for (int n = 0; n < ncyc + 600; n++) begin
      gen = (n < ncyc);
      if (m_act && cyc >= m_t + m_k + 2) m_act = 1'b0;
      if (gen)
        for (int i = 0; i < N; i++)
          if (!pend[i] && $urandom_range(99) < p_new) new_req(i, all_wr);
      drive_reqs();
      exp_rdy = '0;
      g_now   = 1'b0;
      if (!m_act)
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (pend[j] && !g_now) begin
            g_now = 1'b1;
            m_act = 1'b1;
            m_g   = j;
            m_t   = cyc;
            d     = (fix_d > 0) ? fix_d : int'($urandom_range(20, 1));
            m_to  = (d > TO);
            m_k   = m_to ? TO : d;
            m_w   = pw[j];
            m_a   = pa[j];
            m_d   = pd[j];
            m_b   = pb[j];
            m_cd  = fix_cd_en ? fix_cd : $urandom;
            m_ptr = (j + 1) % N;
            pend[j] = 1'b0;
            exp_rdy = N'(1) << j;
          end
        end
      in_acc  = m_act && cyc >= m_t + 1 && cyc <= m_t + m_k;
      in_resp = m_act && cyc == m_t + m_k + 1;
      bus.cfg_mgmt_read_write_done = 1'b0;
      bus.cfg_mgmt_read_data       = $urandom;
      if (m_act && !m_to && cyc == m_t + m_k) begin
        bus.cfg_mgmt_read_write_done = 1'b1;
        bus.cfg_mgmt_read_data       = m_cd;
      end else if (!in_acc && ((stale && $urandom_range(7) == 0) || (stale_first && g_now)))
        bus.cfg_mgmt_read_write_done = 1'b1;
      #1;
      chk("ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("rd_strb", 32'(bus.cfg_mgmt_read), 32'(in_acc && !m_w));
      chk("wr_strb", 32'(bus.cfg_mgmt_write), 32'(in_acc && m_w));
      if (in_acc) begin
        chk("addr", 32'(bus.cfg_mgmt_addr), 32'(m_a));
        chk("wdata", bus.cfg_mgmt_write_data, m_d);
        chk("be", 32'(bus.cfg_mgmt_byte_enable), 32'(m_b));
      end
      chk("resp_valid", 32'(bus.resp_valid), in_resp ? 32'(N'(1) << m_g) : 32'h0);
      if (in_resp) begin
        m_last_rd = m_to ? 32'hFFFF_FFFF : (m_w ? 32'h0 : m_cd);
        m_last_to = m_to;
        seen_rd   = bus.resp_rdata;
        seen_to   = bus.resp_timeout;
      end
      chk("resp_rdata", bus.resp_rdata, m_last_rd);
      chk("resp_to", 32'(bus.resp_timeout), 32'(m_last_to));
      step();
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= pend[i];
      if (!gen && !any && (!m_act || cyc >= m_t + m_k + 2)) begin
        drained = 1'b1;
        break;
      end
    end
    bus.cfg_mgmt_read_write_done = 1'b0;
    drive_reqs();
    if (!drained) begin
      n_chk++; n_fail++;
      $display("FAIL drain cyc=%0d got=busy exp=idle", cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pw[i] = 1'b0; pa[i] = '0; pd[i] = '0; pb[i] = '0;
    end
    drive_reqs();
    bus.cfg_mgmt_read_write_done = 1'b0;
    bus.cfg_mgmt_read_data       = '0;
    #1 rst_n = 1'b0;
    #2 chk_zero("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // all requesters hammering with writes, done after one cycle: strict 0,1,2,3 rotation
    run(40, 100, 1'b1, 1, 1'b0, 32'h0, 1'b0, 1'b0);

    tbl[0] = '{0, 1'b0, 19'h00004, 32'h0, 4'hF, 3,  32'h10EE7038, 1'b0, 32'h10EE7038, 1'b0};
    tbl[1] = '{1, 1'b1, 19'h7FFFF, 32'hA5A5A5A5, 4'hF, 50, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1};
    tbl[2] = '{3, 1'b0, 19'h00123, 32'h0, 4'h3, 16, 32'h12345678, 1'b0, 32'h12345678, 1'b0};
    tbl[3] = '{2, 1'b0, 19'h00ABC, 32'h0, 4'hF, 1,  32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0};
    tbl[4] = '{0, 1'b1, 19'h40000, 32'hDEADBEEF, 4'h5, 2, 32'h55555555, 1'b0, 32'h0, 1'b0};
    tbl[5] = '{1, 1'b0, 19'h00010, 32'h0, 4'hF, 17, 32'h0BADC0DE, 1'b0, 32'hFFFF_FFFF, 1'b1};
    tbl[6] = '{2, 1'b0, 19'h00020, 32'h0, 4'hC, 15, 32'h87654321, 1'b0, 32'h87654321, 1'b0};
    for (int e = 0; e < 7; e++) begin
      pend[tbl[e].req] = 1'b1;
      pw[tbl[e].req]   = tbl[e].wr;
      pa[tbl[e].req]   = tbl[e].a;
      pd[tbl[e].req]   = tbl[e].wd;
      pb[tbl[e].req]   = tbl[e].be;
      run(0, 0, 1'b0, tbl[e].d, 1'b1, tbl[e].cd, 1'b0, tbl[e].stale);
      chk("tbl_rdata", seen_rd, tbl[e].erd);
      chk("tbl_timeout", 32'(seen_to), 32'(tbl[e].eto));
    end

    run(3000, 30, 1'b0, 0, 1'b0, 32'h0, 1'b1, 1'b0);

    // reset in the middle of an access: no response, pointer back to 0, late done ignored
    pend[1] = 1'b1; pw[1] = 1'b0; pa[1] = 19'h00777; pd[1] = '0; pb[1] = 4'hF;
    drive_reqs();
    #1 chk("mid_ready", 32'(bus.req_ready), 32'h2);
    pend[1] = 1'b0;
    step();
    drive_reqs();
    #1 chk("mid_rd", 32'(bus.cfg_mgmt_read), 32'h1);
    step();
    step();
    #1 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    step();
    rst_n = 1'b1;
    bus.cfg_mgmt_read_write_done = 1'b1;
    bus.cfg_mgmt_read_data       = 32'h13579BDF;
    #1 chk("spur_rvalid", 32'(bus.resp_valid), 32'h0);
    step();
    bus.cfg_mgmt_read_write_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rvalid", 32'(bus.resp_valid), 32'h0);
      chk("post_strb", 32'({bus.cfg_mgmt_write, bus.cfg_mgmt_read}), 32'h0);
      chk("post_rdata", bus.resp_rdata, 32'h0);
      step();
    end
    m_ptr = 0; m_act = 1'b0; m_last_rd = '0; m_last_to = 1'b0;
    for (int i = 0; i < N; i++) new_req(i, 1'b0);
    run(0, 0, 1'b0, 2, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
